// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-requester memory access arbiter.
// Holds the FSM state encoding, the read/write direction codes and the
// width of the read-latency counter.
package mem_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Requester direction codes
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Read-latency counter width; covers RD_LAT up to 7
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
// Ports:
//   Clk, Reset - clock, asynchronous active-low reset
//   elig       - per-requester eligibility
//   en         - arbitration enable; no grant and no history update when low
//   gnt_c      - one-hot grant, combinational
// The last granted index is remembered; on a tie the other requester wins.
// Reset leaves lastGnt = 1 so requester 0 wins the first tie.
module rr_arbiter_2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] elig,
    input  logic       en,
    output logic [1:0] gnt_c
);

    logic lastGnt;

    // Grant selection
    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            if (elig == 2'b11) begin
                gnt_c = lastGnt ? 2'b01 : 2'b10;
            end else begin
                gnt_c = elig;
            end
        end
    end

    // Remember who was served last
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lastGnt <= 1'b1;
        end else if (|gnt_c) begin
            lastGnt <= gnt_c[1];
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between two single-access requesters.
// Ports:
//   Clk, Reset                  - clock, asynchronous active-low reset
//   Req/RW/Addr/WData 0 and 1   - requester access requests (Req is a level)
//   Gnt0/Gnt1                   - ownership, ACCESS through DONE
//   Done0/Done1                 - one-cycle completion pulse
//   RData                       - captured read data, held until next capture
//   MemEn/MemWr/MemAddr/MemWData/MemRData - memory macro interface
//   Busy                        - FSM not idle
// Every output is a register; Reset clears them all asynchronously.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          RW0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] WData0,
    input  logic          Req1,
    input  logic          RW1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          Done0,
    output logic          Done1,
    output logic [DW-1:0] RData,
    output logic          MemEn,
    output logic          MemWr,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          Busy
);

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [1:0]       gnt;
    logic [1:0]       gntNext;
    logic [1:0]       done;
    logic [1:0]       doneNext;
    logic [1:0]       armed;
    logic [1:0]       armedNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             memEnNext;
    logic             memWrNext;
    logic [AW-1:0]    memAddrNext;
    logic [DW-1:0]    memWDataNext;
    logic [DW-1:0]    rDataNext;
    logic             busyNext;
    logic             arbEn;
    logic [1:0]       elig;
    logic [1:0]       grantC;

    // A held Req must be seen low once before it may start another access
    assign elig = {Req1 & armed[1], Req0 & armed[0]};

    rr_arbiter_2 u_rr (
        .Clk   (Clk),
        .Reset (Reset),
        .elig  (elig),
        .en    (arbEn),
        .gnt_c (grantC)
    );

    assign Gnt0  = gnt[0];
    assign Gnt1  = gnt[1];
    assign Done0 = done[0];
    assign Done1 = done[1];

    // Next-state and next-output logic
    always_comb begin
        stateNext    = state;
        gntNext      = gnt;
        doneNext     = 2'b00;
        cntNext      = cnt;
        memEnNext    = 1'b0;
        memWrNext    = 1'b0;
        memAddrNext  = MemAddr;
        memWDataNext = MemWData;
        rDataNext    = RData;
        arbEn        = 1'b0;

        // Low Req re-arms; finishing an access disarms the served requester
        armedNext[0] = !Req0 ? 1'b1 : ((state == ST_DONE && gnt[0]) ? 1'b0 : armed[0]);
        armedNext[1] = !Req1 ? 1'b1 : ((state == ST_DONE && gnt[1]) ? 1'b0 : armed[1]);

        case (state)
            ST_IDLE: begin
                arbEn = 1'b1;
                if (|grantC) begin
                    stateNext    = ST_ACCESS;
                    gntNext      = grantC;
                    memEnNext    = 1'b1;
                    memWrNext    = grantC[1] ? RW1    : RW0;
                    memAddrNext  = grantC[1] ? Addr1  : Addr0;
                    memWDataNext = grantC[1] ? WData1 : WData0;
                end
            end
            ST_ACCESS: begin
                // MemWr still carries the latched direction here
                if (MemWr == RW_WRITE) begin
                    stateNext = ST_DONE;
                    doneNext  = gnt;
                end else begin
                    cntNext   = CNT_W'(RD_LAT);
                    stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    rDataNext = MemRData;
                    stateNext = ST_DONE;
                    doneNext  = gnt;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
                gntNext   = 2'b00;
            end
            default: begin
                stateNext = ST_IDLE;
                gntNext   = 2'b00;
            end
        endcase

        busyNext = (stateNext != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            gnt      <= 2'b00;
            done     <= 2'b00;
            armed    <= 2'b11;
            cnt      <= '0;
            MemEn    <= 1'b0;
            MemWr    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            RData    <= '0;
            Busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            gnt      <= gntNext;
            done     <= doneNext;
            armed    <= armedNext;
            cnt      <= cntNext;
            MemEn    <= memEnNext;
            MemWr    <= memWrNext;
            MemAddr  <= memAddrNext;
            MemWData <= memWDataNext;
            RData    <= rDataNext;
            Busy     <= busyNext;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a RD_LAT = 2 memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_arbiter;

    logic       Clk;
    logic       Reset;
    logic       Req0, RW0, Req1, RW1;
    logic [7:0] Addr0, WData0, Addr1, WData1;
    logic       Gnt0, Gnt1, Done0, Done1;
    logic [7:0] RData;
    logic       MemEn, MemWr;
    logic [7:0] MemAddr, MemWData, MemRData;
    logic       Busy;

    int testsRun  = 0;
    int failCount = 0;

    mem_access_arbiter #(.AW(8), .DW(8), .RD_LAT(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req0     (Req0),
        .RW0      (RW0),
        .Addr0    (Addr0),
        .WData0   (WData0),
        .Req1     (Req1),
        .RW1      (RW1),
        .Addr1    (Addr1),
        .WData1   (WData1),
        .Gnt0     (Gnt0),
        .Gnt1     (Gnt1),
        .Done0    (Done0),
        .Done1    (Done1),
        .RData    (RData),
        .MemEn    (MemEn),
        .MemWr    (MemWr),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: read data valid exactly two cycles after the MemEn cycle
    logic [7:0] mem [256];
    logic       s1v = 1'b0, s2v = 1'b0;
    logic [7:0] s1a = 8'h00, s2a = 8'h00;
    always @(posedge Clk) begin
        if (MemEn && MemWr) mem[MemAddr] <= MemWData;
        s1v <= MemEn && !MemWr;
        s1a <= MemAddr;
        s2v <= s1v;
        s2a <= s1a;
    end
    assign MemRData = s2v ? mem[s2a] : 8'hEE;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int   order[$];
    int   d0, d1, ovl, g, d;
    logic pg0, pg1, raise0, raise1, seen;

    initial begin
        Req0 = 0; RW0 = 0; Addr0 = 0; WData0 = 0;
        Req1 = 0; RW1 = 0; Addr1 = 0; WData1 = 0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset state
        checkVal("rst_ctrl", 32'({Gnt1, Gnt0, Done1, Done0, MemEn, MemWr, Busy}), 32'b0);
        checkVal("rst_addr", 32'({MemAddr, MemWData}), 32'h0);
        checkVal("rst_rdata", 32'(RData), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // Test 1: requester 0 write
        Req0 = 1; RW0 = 1; Addr0 = 8'h10; WData0 = 8'hA5;
        @(negedge Clk);
        checkVal("t1_en_wr", 32'({MemEn, MemWr}), 32'b11);
        checkVal("t1_addr", 32'(MemAddr), 32'h10);
        checkVal("t1_wdata", 32'(MemWData), 32'hA5);
        checkVal("t1_gnt", 32'({Gnt1, Gnt0, Busy}), 32'b011);
        Req0 = 0; Addr0 = 8'hFF; WData0 = 8'h00;
        @(negedge Clk);
        checkVal("t1_done", 32'({Done1, Done0, Gnt0, MemEn}), 32'b0110);
        checkVal("t1_addr_hold", 32'(MemAddr), 32'h10);
        @(negedge Clk);
        checkVal("t1_idle", 32'({Busy, Gnt0, Done0}), 32'b000);

        // Test 2: requester 1 read, Done four cycles after the request edge
        Req1 = 1; RW1 = 0; Addr1 = 8'h10;
        @(negedge Clk);
        checkVal("t2_access", 32'({MemEn, MemWr, Gnt1}), 32'b101);
        Req1 = 0;
        @(negedge Clk);
        checkVal("t2_wait1", 32'({MemEn, Busy, Done1}), 32'b010);
        @(negedge Clk);
        checkVal("t2_wait2", 32'({Busy, Done1}), 32'b10);
        @(negedge Clk);
        checkVal("t2_done", 32'({Done1, Gnt1}), 32'b11);
        checkVal("t2_rdata", 32'(RData), 32'hA5);
        @(negedge Clk);
        checkVal("t2_idle", 32'({Busy, Gnt1, Done1}), 32'b000);

        // Test 3: simultaneous writers, four alternating rounds
        RW0 = 1; Addr0 = 8'h20; WData0 = 8'h3C;
        RW1 = 1; Addr1 = 8'h30; WData1 = 8'hC3;
        Req0 = 1; Req1 = 1;
        d0 = 0; d1 = 0; ovl = 0; pg0 = 0; pg1 = 0; raise0 = 0; raise1 = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge Clk);
            if (raise0) begin Req0 = 1; raise0 = 0; end
            if (raise1) begin Req1 = 1; raise1 = 0; end
            if (Gnt0 && Gnt1) ovl++;
            if (Gnt0 && !pg0) order.push_back(0);
            if (Gnt1 && !pg1) order.push_back(1);
            pg0 = Gnt0;
            pg1 = Gnt1;
            if (Done0) begin d0++; Req0 = 0; raise0 = (order.size() < 3); end
            if (Done1) begin d1++; Req1 = 0; raise1 = (order.size() < 3); end
        end
        checkVal("t3_ngrants", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("t3_order%0d", i),
                     32'((i < order.size()) ? order[i] : 99), 32'(i % 2));
        end
        checkVal("t3_done0", 32'(d0), 32'd2);
        checkVal("t3_done1", 32'(d1), 32'd2);
        checkVal("t3_overlap", 32'(ovl), 32'd0);

        // Test 4: held request gives one access only
        RW0 = 1; Addr0 = 8'h40; WData0 = 8'h77; Req0 = 1;
        g = 0; d = 0; pg0 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (Gnt0 && !pg0) g++;
            if (Done0) d++;
            pg0 = Gnt0;
        end
        checkVal("t4_held_gnt", 32'(g), 32'd1);
        checkVal("t4_held_done", 32'(d), 32'd1);
        Req0 = 0;
        @(negedge Clk);
        Req0 = 1;
        g = 0; d = 0; pg0 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (Gnt0 && !pg0) g++;
            if (Done0) d++;
            pg0 = Gnt0;
        end
        checkVal("t4_rearm_gnt", 32'(g), 32'd1);
        checkVal("t4_rearm_done", 32'(d), 32'd1);
        Req0 = 0;
        @(negedge Clk);

        // Test 5: reset while a read waits
        RW0 = 0; Addr0 = 8'h20; Req0 = 1;
        @(negedge Clk);
        @(negedge Clk);
        checkVal("t5_pre", 32'({Busy, Gnt0, MemEn}), 32'b110);
        Reset = 1'b0;
        #1;
        checkVal("t5_abort", 32'({Busy, Gnt0, Gnt1, MemEn, MemWr}), 32'b0);
        Req0 = 0;
        @(negedge Clk);
        Reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (Done0 || Done1 || Busy) seen = 1;
        end
        checkVal("t5_no_done", 32'(seen), 32'd0);
        checkVal("t5_rdata_rst", 32'(RData), 32'h0);
        RW1 = 0; Addr1 = 8'h10; Req1 = 1;
        @(negedge Clk);
        checkVal("t5_r1_access", 32'({MemEn, MemWr, Gnt1}), 32'b101);
        Req1 = 0;
        repeat (3) @(negedge Clk);
        checkVal("t5_r1_done", 32'({Done1, Gnt1}), 32'b11);
        checkVal("t5_r1_rdata", 32'(RData), 32'hA5);
        @(negedge Clk);

        // Test 6: requester 1 arrives while requester 0 read is in WAIT
        RW0 = 0; Addr0 = 8'h20; Req0 = 1;
        @(negedge Clk);
        @(negedge Clk);
        RW1 = 0; Addr1 = 8'h30; Req1 = 1;
        @(negedge Clk);
        checkVal("t6_wait_gnt1", 32'(Gnt1), 32'd0);
        checkVal("t6_wait_rdata", 32'(RData), 32'hA5);
        @(negedge Clk);
        checkVal("t6_done0", 32'({Done0, Gnt1}), 32'b10);
        checkVal("t6_rdata0", 32'(RData), 32'h3C);
        Req0 = 0;
        @(negedge Clk);
        checkVal("t6_idle", 32'({Busy, Gnt1, Gnt0}), 32'b000);
        @(negedge Clk);
        checkVal("t6_gnt1", 32'({Gnt1, MemEn, MemWr}), 32'b110);
        Req1 = 0;
        @(negedge Clk);
        @(negedge Clk);
        checkVal("t6_rdata_hold", 32'(RData), 32'h3C);
        @(negedge Clk);
        checkVal("t6_done1", 32'(Done1), 32'd1);
        checkVal("t6_rdata1", 32'(RData), 32'hC3);
        @(negedge Clk);
        checkVal("t6_end", 32'({Busy, Done1, Gnt1}), 32'b000);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
